// File: rtl/wb_bfm_arbiter.sv
// Round-robin Wishbone B3 arbiter: one slave shared by NUM_MASTERS masters, owner keeps the bus for its whole cycle.
// Optional macro WB_BFM_ARB_WATCHDOG_EN adds a no-response watchdog that aborts a hung owner after TIMEOUT cycles.
module wb_bfm_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [DW-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);
  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;

  generate
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
      $error("wb_bfm_arbiter: parameter out of range");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_n;
  logic [NUM_MASTERS-1:0] grant, grant_n;
  logic [LW-1:0]          last, last_n;
  logic [LW-1:0]          pick, idx;
  logic                   found;
  logic                   abort;

  // Search starts just after the previous owner, so every requester is reached within NUM_MASTERS grants.
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = LW'((int'(last) + k) % NUM_MASTERS);
      if (!found && wbm_cyc_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      last  <= LW'(NUM_MASTERS - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      last  <= last_n;
    end
  end

  // In BUSY the owner index is held in last; only the owner's cyc can end the cycle.
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          grant_n = NUM_MASTERS'(1) << pick;
          last_n  = pick;
        end
      end
      BUSY: begin
        if (!wbm_cyc_i[last] || abort) begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

`ifdef WB_BFM_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        resp;

  assign resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign abort = (state == BUSY) && (wd_cnt == 16'(TIMEOUT));

  // Held at zero outside BUSY, so every new owner starts with a fresh count.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      wd_cnt <= '0;
    else if (state != BUSY || resp)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 16'd1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && abort)
      $display("wb_bfm_arbiter: watchdog timeout, owner %0d, adr 0x%h", last, wbs_adr_o);
  end
`endif
`else
  assign abort = 1'b0;
`endif

  // grant is all-zero in IDLE and under reset, which zeroes every slave-side output.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        wbs_adr_o = wbm_adr_i[i*AW +: AW];
        wbs_dat_o = wbm_dat_i[i*DW +: DW];
        wbs_sel_o = wbm_sel_i[i*SW +: SW];
        wbs_we_o  = wbm_we_i[i];
        wbs_cyc_o = wbm_cyc_i[i];
        wbs_stb_o = wbm_stb_i[i];
        wbs_cti_o = wbm_cti_i[i*3 +: 3];
        wbs_bte_o = wbm_bte_i[i*2 +: 2];
      end
    end
    if (abort) begin
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
    end
  end

  assign wbm_ack_o = grant & {NUM_MASTERS{wbs_ack_i}};
  assign wbm_err_o = grant & {NUM_MASTERS{wbs_err_i | abort}};
  assign wbm_rty_o = grant & {NUM_MASTERS{wbs_rty_i}};
  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = grant;

endmodule

// File: tb/tb_wb_bfm_arbiter.sv
// Bench for wb_bfm_arbiter: two masters, a randomized-latency memory slave and a round-robin ownership model.
module tb_wb_bfm_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] m_adr [N];
  logic [DW-1:0] m_dat [N];
  logic          m_we  [N];
  logic          m_cyc [N];
  logic          m_stb [N];
  logic [2:0]    m_cti [N];
  logic [1:0]    m_bte [N];

  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*SW-1:0] wbm_sel_i;
  logic [N-1:0]    wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [N*3-1:0]  wbm_cti_i;
  logic [N*2-1:0]  wbm_bte_i;
  logic [DW-1:0]   wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [SW-1:0]   wbs_sel_o;
  logic            wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;
  logic [DW-1:0]   wbs_dat_i = 32'hCAFE_0001;
  logic            wbs_ack_i = 1'b0;
  logic            wbs_err_i = 1'b0;
  logic            wbs_rty_i = 1'b0;

  always_comb begin
    wbm_sel_i = '1;
    for (int i = 0; i < N; i++) begin
      wbm_adr_i[i*AW +: AW] = m_adr[i];
      wbm_dat_i[i*DW +: DW] = m_dat[i];
      wbm_we_i[i]           = m_we[i];
      wbm_cyc_i[i]          = m_cyc[i];
      wbm_stb_i[i]          = m_stb[i];
      wbm_cti_i[i*3 +: 3]   = m_cti[i];
      wbm_bte_i[i*2 +: 2]   = m_bte[i];
    end
  end

  wb_bfm_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .grant_o(grant_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_init(input int i);
    return 32'hA5A5_0000 | i;
  endfunction

  // Memory slave: 256 words, registered ack after 0..2 random wait cycles.
  logic [31:0]   mem [256];
  logic [31:0]   ref_mem [256];
  int            lat = 0;
  logic [AW-1:0] beat_adr [$];

  always @(posedge clk) begin
    if (rst) begin
      wbs_ack_i <= 1'b0;
      lat       <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
    end else begin
      wbs_ack_i <= 1'b0;
      if (wbs_cyc_o && wbs_stb_o && !wbs_ack_i) begin
        if (lat == 0) begin
          wbs_ack_i <= 1'b1;
          if (wbs_we_o) mem[wbs_adr_o[9:2]] <= wbs_dat_o;
          else          wbs_dat_i <= mem[wbs_adr_o[9:2]];
          beat_adr.push_back(wbs_adr_o);
          lat <= int'($urandom_range(0, 2));
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  // Ownership model: requests seen at each rising edge, checked half a cycle later.
  int           mdl_last = N - 1;
  int           glog [$];
  logic [N-1:0] p_grant = '0;

  function automatic int rr_pick(input int from, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++)
      if (req[(from + k) % N]) return (from + k) % N;
    return from;
  endfunction

  initial begin
    logic [N-1:0] e_cyc, exp_g;
    logic         e_rst;
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) e_cyc[i] = m_cyc[i];
      e_rst = rst;
      @(negedge clk);
      if (rst || e_rst) begin
        check("rst_grant", grant_o, 0);
        check("rst_cyc", wbs_cyc_o, 0);
        check("rst_ack", wbm_ack_o, 0);
        mdl_last = N - 1;
        exp_g    = '0;
      end else begin
        if (p_grant == 0) begin
          exp_g = '0;
          if (e_cyc != 0) begin
            mdl_last = rr_pick(mdl_last, e_cyc);
            exp_g    = N'(1) << mdl_last;
            glog.push_back(mdl_last);
          end
        end else if ((e_cyc & p_grant) == 0) begin
          exp_g = '0;
        end else begin
          exp_g = p_grant;
        end
        check("grant", grant_o, exp_g);
        if (exp_g != 0) begin
          check("s_cyc", wbs_cyc_o, m_cyc[mdl_last]);
          check("s_stb", wbs_stb_o, m_stb[mdl_last]);
          check("s_adr", wbs_adr_o, m_adr[mdl_last]);
          check("s_dat", wbs_dat_o, m_dat[mdl_last]);
          check("s_we",  wbs_we_o,  m_we[mdl_last]);
          check("s_cti", wbs_cti_o, m_cti[mdl_last]);
          check("s_bte", wbs_bte_o, m_bte[mdl_last]);
          check("s_sel", wbs_sel_o, 4'hF);
        end else begin
          check("idle_cyc", wbs_cyc_o, 0);
          check("idle_stb", wbs_stb_o, 0);
          check("idle_adr", wbs_adr_o, 0);
          check("idle_sel", wbs_sel_o, 0);
        end
        check("ack_route", wbm_ack_o, exp_g & {N{wbs_ack_i}});
        check("err_route", wbm_err_o, 0);
        check("rty_route", wbm_rty_o, 0);
      end
      check("m_dat", wbm_dat_o, wbs_dat_i);
      p_grant = exp_g;
    end
  end

  // All master tasks are entered and left just after a rising edge.
  task automatic single(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    int n;
    m_adr[m] = adr; m_dat[m] = dat; m_we[m] = we; m_cti[m] = 3'b000; m_bte[m] = 2'b00;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wbm_ack_o[m] && n < 300);
    check("single_ack", wbm_ack_o[m], 1);
    if (we) ref_mem[adr[9:2]] = dat;
    else    check("single_rdata", wbm_dat_o, ref_mem[adr[9:2]]);
    #1;
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic burst(input int m, input logic we, input logic [31:0] base, input int len);
    int n;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we; m_bte[m] = 2'b00;
    for (int b = 0; b < len; b++) begin
      m_adr[m] = base + 32'(4 * b);
      m_dat[m] = $urandom;
      m_cti[m] = (b == len - 1) ? 3'b111 : 3'b010;
      n = 0;
      do begin @(negedge clk); n++; end while (!wbm_ack_o[m] && n < 300);
      check("burst_ack", wbm_ack_o[m], 1);
      check("burst_grant", grant_o, N'(1) << m);
      if (we) ref_mem[m_adr[m][9:2]] = m_dat[m];
      else    check("burst_rdata", wbm_dat_o, ref_mem[m_adr[m][9:2]]);
      #1;
    end
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0; m_cti[m] = 3'b000;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, s, bs;
    for (int i = 0; i < N; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_we[i] = 1'b0; m_cyc[i] = 1'b0;
      m_stb[i] = 1'b0; m_cti[i] = '0; m_bte[i] = '0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);

    // Reset state
    @(negedge clk);
    check("reset_grant", grant_o, 0);
    check("reset_cyc", wbs_cyc_o, 0);
    check("reset_stb", wbs_stb_o, 0);
    check("reset_adr", wbs_adr_o, 0);
    check("reset_dat_pass", wbm_dat_o, 32'hCAFE_0001);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // m0 single read at 0x100: one cycle of arbitration latency
    m_adr[0] = 32'h100; m_we[0] = 1'b0; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(negedge clk);
    check("latency_idle_cyc", wbs_cyc_o, 0);
    @(negedge clk);
    check("first_cyc", wbs_cyc_o, 1);
    check("first_adr", wbs_adr_o, 32'h100);
    check("first_grant", grant_o, 2'b01);
    n = 0;
    while (!wbm_ack_o[0] && n < 300) begin @(negedge clk); n++; end
    check("first_ack", wbm_ack_o, 2'b01);
    check("first_rdata", wbm_dat_o, mem_init(64));
    #1; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests after reset: m0 then m1
    pulse_reset();
    s = glog.size();
    fork
      single(0, 1'b1, 32'h010, $urandom);
      single(1, 1'b1, 32'h020, $urandom);
    join
    check("simul_count", glog.size() - s, 2);
    if (glog.size() >= s + 2) begin
      check("simul_first", glog[s], 0);
      check("simul_second", glog[s+1], 1);
    end

    // Back-to-back traffic, 20 transactions per master
    s = glog.size();
    fork
      begin
        logic [31:0] d0;
        for (int k = 0; k < 10; k++) begin
          d0 = $urandom;
          single(0, 1'b1, 32'h200 + 32'(4 * k), d0);
          single(0, 1'b0, 32'h200 + 32'(4 * k), 32'h0);
        end
      end
      begin
        logic [31:0] d1;
        for (int k = 0; k < 10; k++) begin
          d1 = $urandom;
          single(1, 1'b1, 32'h300 + 32'(4 * k), d1);
          single(1, 1'b0, 32'h300 + 32'(4 * k), 32'h0);
        end
      end
    join
    check("b2b_count", glog.size() - s, 40);
    for (int k = s + 1; k < glog.size(); k++)
      check("b2b_alternate", glog[k], 1 - glog[k-1]);

    // m1 8-beat incrementing burst while m0 requests
    s  = glog.size();
    bs = beat_adr.size();
    fork
      burst(1, 1'b1, 32'h080, 8);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        single(0, 1'b0, 32'h100, 32'h0);
      end
    join
    check("burst_order_count", glog.size() - s, 2);
    if (glog.size() >= s + 2) begin
      check("burst_owner_first", glog[s], 1);
      check("burst_m0_after", glog[s+1], 0);
    end
    check("burst_beats", beat_adr.size() - bs, 9);
    if (beat_adr.size() >= bs + 9)
      for (int b = 0; b < 8; b++) check("burst_beat_adr", beat_adr[bs+b], 32'h080 + 32'(4 * b));
    burst(1, 1'b0, 32'h080, 8);

    // Asynchronous reset in the middle of an m1 burst
    m_adr[1] = 32'h0C0; m_we[1] = 1'b0; m_cti[1] = 3'b010; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!grant_o[1] && n < 50);
    check("rst_burst_grant", grant_o, 2'b10);
    #1; m_adr[0] = 32'h040; m_we[0] = 1'b0; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cyc", wbs_cyc_o, 0);
    check("async_rst_stb", wbs_stb_o, 0);
    check("async_rst_grant", grant_o, 0);
    check("async_rst_ack", wbm_ack_o, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
    @(negedge clk);
    check("post_rst_grant", grant_o, 2'b01);
    check("post_rst_adr", wbs_adr_o, 32'h040);
    #1;
    for (int i = 0; i < N; i++) begin m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_cti[i] = '0; end
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
